// File: rtl/pwm_sched.sv
// ---------------------------------------------------------------------------
// pwm_sched
//
// Pointwise polynomial multiply scheduler. Streams NCOEF coefficient pairs from
// the A/B coefficient memories into the shared pipelined mod-q multiplier.
// A {valid, addr} delay line tracks each coefficient in flight. Reduced
// products are written back to the result memory at one coefficient per cycle.
//
// Optional feature: define PWM_ACC_EN to select accumulate mode (C += A*B).
// This adds the c_data port, delays c_data alongside the multiplier, and adds
// it to the product with a single conditional subtraction of Q.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             one-cycle request, sampled only while idle
//   busy, done        operation in progress / one-cycle completion pulse
//   rd_en, rd_addr    read strobe and address for the A, B (and C) memories
//   a_data, b_data    memory read data, valid the cycle after rd_en
//   c_data            (PWM_ACC_EN only) C memory read data, same timing
//   mul_in1, mul_in2  multiplier operands, zero when no operand is in flight
//   mul_res           reduced product, MULT_LAT cycles after the operands
//   wr_en, wr_addr    result write strobe and address
//   wr_data           result value
// ---------------------------------------------------------------------------
module pwm_sched #(
    parameter int NCOEF    = 256,
    parameter int AW       = 8,
    parameter int MULT_LAT = 4,
    parameter int Q        = 3329
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [11:0]   a_data,
    input  logic [11:0]   b_data,
`ifdef PWM_ACC_EN
    input  logic [11:0]   c_data,
`endif
    output logic [11:0]   mul_in1,
    output logic [11:0]   mul_in2,
    input  logic [11:0]   mul_res,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [11:0]   wr_data
);

    // Tap 0 holds the coefficient whose memory data is on a_data/b_data this
    // cycle; tap DEPTH-1 holds the one whose product is on mul_res.
    localparam int DEPTH = MULT_LAT + 1;

    if (AW != $clog2(NCOEF) || Q >= 4096 || MULT_LAT < 1) begin : g_bad_params
        $error("pwm_sched: need AW == log2(NCOEF), Q < 4096, MULT_LAT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [DEPTH-1:0] vld;
    logic [AW-1:0]   addr_dly [DEPTH];
    logic            last_issue;
    logic            last_write;
    logic [11:0]     result;

    assign last_issue = (rd_addr == AW'(NCOEF - 1));
    assign last_write = vld[DEPTH-1] && (addr_dly[DEPTH-1] == AW'(NCOEF - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = RUN;
            RUN:     if (last_issue) state_next = DRAIN;
            DRAIN:   if (last_write) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_en = (state == RUN);
        busy  = (state != IDLE);
    end

    // The address wraps back to 0 after the last issue, so it already reads 0
    // while idle; the explicit clear on start keeps that true after any reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr <= '0;
        end else if (state == IDLE && start) begin
            rd_addr <= '0;
        end else if (state == RUN) begin
            rd_addr <= rd_addr + AW'(1);
        end
    end

    // done is registered so it lands in the first idle cycle after the last
    // write, which is also the cycle in which a new start can be accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state == DRAIN) && last_write;
        end
    end

    // Clearing the valid bits on reset is what suppresses writes for
    // operations that were still inside the multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                addr_dly[k] <= '0;
            end
        end else begin
            vld         <= {vld[DEPTH-2:0], rd_en};
            addr_dly[0] <= rd_addr;
            for (int k = 1; k < DEPTH; k++) begin
                addr_dly[k] <= addr_dly[k-1];
            end
        end
    end

    assign mul_in1 = vld[0] ? a_data : 12'd0;
    assign mul_in2 = vld[0] ? b_data : 12'd0;

`ifdef PWM_ACC_EN
    logic [11:0] c_dly [MULT_LAT];
    logic [12:0] sum;

    // c_data travels alongside the multiplier so it meets its own product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MULT_LAT; k++) begin
                c_dly[k] <= '0;
            end
        end else begin
            c_dly[0] <= vld[0] ? c_data : 12'd0;
            for (int k = 1; k < MULT_LAT; k++) begin
                c_dly[k] <= c_dly[k-1];
            end
        end
    end

    // Both addends are below Q, so one conditional subtraction fully reduces.
    assign sum    = {1'b0, mul_res} + {1'b0, c_dly[MULT_LAT-1]};
    assign result = (sum >= 13'(Q)) ? 12'(sum - 13'(Q)) : sum[11:0];
`else
    assign result = mul_res;
`endif

    // wr_data is forced to zero when no write is pending, so a reset also
    // hides any multiplier result that is still arriving.
    assign wr_en   = vld[DEPTH-1];
    assign wr_addr = addr_dly[DEPTH-1];
    assign wr_data = vld[DEPTH-1] ? result : 12'd0;

endmodule

// File: tb/tb_pwm_sched.sv
// ---------------------------------------------------------------------------
// tb_pwm_sched
//
// Self-checking bench for pwm_sched. Surrounds the DUT with coefficient
// memories and a pipelined mod-q multiplier. Logs every DUT output per cycle,
// then checks each run against absolute timing windows computed from c0. The
// expected results come from plain modular arithmetic on the memory contents.
// Define PWM_ACC_EN to exercise the accumulate build.
// ---------------------------------------------------------------------------
module tb_pwm_sched;

    localparam int NCOEF    = 256;
    localparam int AW       = 8;
    localparam int MULT_LAT = 4;
    localparam int Q        = 3329;
    localparam int DONE_OFS = NCOEF + MULT_LAT + 1;
    localparam int LOGN     = 16384;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [11:0]   a_data;
    logic [11:0]   b_data;
    logic [11:0]   c_data;
    logic [11:0]   mul_in1;
    logic [11:0]   mul_in2;
    logic [11:0]   mul_res;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int a_mem   [NCOEF];
    int b_mem   [NCOEF];
    int c_mem   [NCOEF];
    int exp_mem [NCOEF];

    logic log_wr    [LOGN];
    int   log_waddr [LOGN];
    int   log_wdata [LOGN];
    logic log_rden  [LOGN];
    int   log_raddr [LOGN];
    logic log_busy  [LOGN];
    logic log_done  [LOGN];

    typedef struct {
        bit ramp;
        int a;
        int b;
        int c;
        int expv;
    } vec_t;

    vec_t vecs[$];
    int   mpipe [MULT_LAT];

    pwm_sched #(
        .NCOEF   (NCOEF),
        .AW      (AW),
        .MULT_LAT(MULT_LAT),
        .Q       (Q)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .a_data (a_data),
        .b_data (b_data),
`ifdef PWM_ACC_EN
        .c_data (c_data),
`endif
        .mul_in1(mul_in1),
        .mul_in2(mul_in2),
        .mul_res(mul_res),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    // Cycle n is the interval after the n-th rising edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Coefficient memories with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= 12'(a_mem[rd_addr]);
            b_data <= 12'(b_mem[rd_addr]);
            c_data <= 12'(c_mem[rd_addr]);
        end
    end

    // Multiplier with MULT_LAT cycles from operands to reduced product. It has
    // no reset, so stale products keep arriving after the DUT is reset.
    always @(posedge clk) begin
        mpipe[0] <= (int'(mul_in1) * int'(mul_in2)) % Q;
        for (int k = 1; k < MULT_LAT; k++) begin
            mpipe[k] <= mpipe[k-1];
        end
    end
    assign mul_res = 12'(mpipe[MULT_LAT-1]);

    // Record every output once per cycle, on the falling edge.
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            log_wr[cyc]    <= wr_en;
            log_waddr[cyc] <= int'(wr_addr);
            log_wdata[cyc] <= int'(wr_data);
            log_rden[cyc]  <= rd_en;
            log_raddr[cyc] <= int'(rd_addr);
            log_busy[cyc]  <= busy;
            log_done[cyc]  <= done;
        end
    end

    // Watchdog so that a stuck bench still ends with a visible failure.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int refModel(input int a, input int b, input int c);
`ifdef PWM_ACC_EN
        return ((a * b) % Q + c) % Q;
`else
        if (c < 0) return -1;
        return (a * b) % Q;
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        for (int i = 0; i < NCOEF; i++) begin
            a_mem[i]   = v.ramp ? i : v.a;
            b_mem[i]   = v.ramp ? 1 : v.b;
            c_mem[i]   = v.ramp ? 0 : v.c;
            exp_mem[i] = v.ramp ? i : v.expv;
        end
    endtask

    task automatic fillRandom();
        for (int i = 0; i < NCOEF; i++) begin
            a_mem[i]   = int'($urandom_range(0, Q - 1));
            b_mem[i]   = int'($urandom_range(0, Q - 1));
            c_mem[i]   = int'($urandom_range(0, Q - 1));
            exp_mem[i] = refModel(a_mem[i], b_mem[i], c_mem[i]);
        end
    endtask

    task automatic pulseStart(output int c0);
        @(negedge clk);
        start = 1'b1;
        c0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitUntil(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Compares one complete run against the timing windows anchored at c0.
    task automatic checkRun(input string name, input int c0);
        int bad_wr;
        int bad_rd;
        int bad_busy;
        int bad_done;
        int t;
        bad_wr = 0;
        bad_rd = 0;
        bad_busy = 0;
        bad_done = 0;
        for (int i = 0; i < NCOEF; i++) begin
            t = c0 + 1 + MULT_LAT + i;
            if (log_wr[t] !== 1'b1 || log_waddr[t] != i || log_wdata[t] != exp_mem[i]) begin
                if (bad_wr == 0)
                    $display("[TB] %s: write %0d at cycle %0d en=%0d addr=%0d data=%0d want %0d",
                             name, i, t, log_wr[t], log_waddr[t], log_wdata[t], exp_mem[i]);
                bad_wr++;
            end
            if (log_rden[c0 + i] !== 1'b1 || log_raddr[c0 + i] != i) bad_rd++;
        end
        for (int k = c0; k < c0 + DONE_OFS; k++) begin
            if (log_busy[k] !== 1'b1) bad_busy++;
            if (log_done[k] !== 1'b0) bad_done++;
        end
        checkOutput({name, "/bad_writes"}, bad_wr, 0);
        checkOutput({name, "/wr_before_first"}, int'(log_wr[c0 + MULT_LAT]), 0);
        checkOutput({name, "/wr_after_last"}, int'(log_wr[c0 + DONE_OFS]), 0);
        checkOutput({name, "/bad_reads"}, bad_rd, 0);
        checkOutput({name, "/rd_en_drain"}, int'(log_rden[c0 + NCOEF]), 0);
        checkOutput({name, "/busy_gaps"}, bad_busy, 0);
        checkOutput({name, "/busy_before"}, int'(log_busy[c0 - 1]), 0);
        checkOutput({name, "/busy_done_cycle"}, int'(log_busy[c0 + DONE_OFS]), 0);
        checkOutput({name, "/early_done"}, bad_done, 0);
        checkOutput({name, "/done_pulse"}, int'(log_done[c0 + DONE_OFS]), 1);
    endtask

    initial begin
        int c0;
        int c0b;
        int dcyc;
        int rcyc;
        int found;
        int first_wr;
        int last_wr;
        int first_done;
        int n_done;
        int first_busy;
        int last_busy;
        int n_bad;

        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < NCOEF; i++) begin
            a_mem[i] = 0;
            b_mem[i] = 0;
            c_mem[i] = 0;
        end

        // Table of constant patterns with hand-computed results.
        vecs.push_back('{ramp: 1'b1, a: 0,    b: 0,    c: 0, expv: 0});
        vecs.push_back('{ramp: 1'b0, a: 3328, b: 3328, c: 0, expv: 1});
        vecs.push_back('{ramp: 1'b0, a: 1234, b: 0,    c: 0, expv: 0});
        vecs.push_back('{ramp: 1'b0, a: 3328, b: 1,    c: 0, expv: 3328});
        vecs.push_back('{ramp: 1'b0, a: 100,  b: 200,  c: 0, expv: 20000 - 6 * 3329});
`ifdef PWM_ACC_EN
        vecs.push_back('{ramp: 1'b0, a: 1000, b: 1,    c: 3000, expv: 671});
        vecs.push_back('{ramp: 1'b0, a: 2,    b: 2,    c: 5,    expv: 9});
        vecs.push_back('{ramp: 1'b0, a: 3328, b: 3328, c: 3328, expv: 0});
`endif

        // Reset state while rst is held.
        @(posedge clk);
        #1;
        checkOutput("reset/busy", int'(busy), 0);
        checkOutput("reset/done", int'(done), 0);
        checkOutput("reset/rd_en", int'(rd_en), 0);
        checkOutput("reset/wr_en", int'(wr_en), 0);
        checkOutput("reset/rd_addr", int'(rd_addr), 0);
        checkOutput("reset/wr_addr", int'(wr_addr), 0);
        checkOutput("reset/wr_data", int'(wr_data), 0);
        @(negedge clk);
        rst = 1'b0;

        // Absolute timing: start held high in cycle 10.
        applyStimulus(vecs[0]);
        while (cyc < 10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitUntil(300);
        first_wr = -1;
        last_wr = -1;
        first_done = -1;
        n_done = 0;
        first_busy = -1;
        last_busy = -1;
        for (int t = 10; t < 295; t++) begin
            if (log_wr[t] === 1'b1) begin
                if (first_wr < 0) first_wr = t;
                last_wr = t;
            end
            if (log_done[t] === 1'b1) begin
                if (first_done < 0) first_done = t;
                n_done++;
            end
            if (log_busy[t] === 1'b1) begin
                if (first_busy < 0) first_busy = t;
                last_busy = t;
            end
        end
        checkOutput("timing/first_wr", first_wr, 16);
        checkOutput("timing/last_wr", last_wr, 271);
        checkOutput("timing/done_cycle", first_done, 272);
        checkOutput("timing/done_count", n_done, 1);
        checkOutput("timing/busy_first", first_busy, 11);
        checkOutput("timing/busy_last", last_busy, 271);
        checkRun("timing", 11);

        // Table-driven constant patterns.
        for (int v = 0; v < vecs.size(); v++) begin
            applyStimulus(vecs[v]);
            pulseStart(c0);
            waitUntil(c0 + DONE_OFS + 3);
            checkRun($sformatf("vec%0d", v), c0);
        end

        // Random coefficients against the arithmetic reference.
        for (int r = 0; r < 3; r++) begin
            fillRandom();
            pulseStart(c0);
            waitUntil(c0 + DONE_OFS + 3);
            checkRun($sformatf("rand%0d", r), c0);
        end

        // start pulses during RUN and DRAIN must not disturb the run.
        fillRandom();
        pulseStart(c0);
        waitUntil(c0 + 50);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitUntil(c0 + NCOEF + 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitUntil(c0 + DONE_OFS + 12);
        checkRun("ignore_start", c0);
        n_bad = 0;
        for (int t = c0 + DONE_OFS + 1; t < c0 + DONE_OFS + 10; t++) begin
            if (log_rden[t] !== 1'b0 || log_busy[t] !== 1'b0 || log_wr[t] !== 1'b0) n_bad++;
        end
        checkOutput("ignore_start/no_restart", n_bad, 0);

        // start asserted in the done cycle launches the next run immediately.
        fillRandom();
        pulseStart(c0);
        found = 0;
        dcyc = 0;
        for (int k = 0; k < NCOEF + MULT_LAT + 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                start = 1'b1;
                dcyc = cyc;
                found = 1;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
        checkOutput("chain/done_seen", found, 1);
        checkOutput("chain/done_cycle", dcyc, c0 + DONE_OFS);
        c0b = dcyc + 1;
        waitUntil(c0b + DONE_OFS + 3);
        checkRun("chain/first", c0);
        checkRun("chain/second", c0b);

        // Reset in the middle of a run: everything drops, nothing is written.
        fillRandom();
        pulseStart(c0);
        found = 0;
        for (int k = 0; k < 300; k++) begin
            if (rd_en === 1'b1 && rd_addr == AW'(100)) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("rst_mid/reached_addr100", found, 1);
        #2;
        rst = 1'b1;
        rcyc = cyc;
        #1;
        checkOutput("rst_mid/busy", int'(busy), 0);
        checkOutput("rst_mid/done", int'(done), 0);
        checkOutput("rst_mid/rd_en", int'(rd_en), 0);
        checkOutput("rst_mid/wr_en", int'(wr_en), 0);
        checkOutput("rst_mid/rd_addr", int'(rd_addr), 0);
        checkOutput("rst_mid/wr_addr", int'(wr_addr), 0);
        checkOutput("rst_mid/wr_data", int'(wr_data), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        waitUntil(rcyc + 20);
        n_bad = 0;
        for (int t = rcyc + 1; t < rcyc + 18; t++) begin
            if (log_wr[t] !== 1'b0 || log_busy[t] !== 1'b0 || log_rden[t] !== 1'b0) n_bad++;
        end
        checkOutput("rst_mid/quiet_after_reset", n_bad, 0);

        fillRandom();
        pulseStart(c0);
        waitUntil(c0 + DONE_OFS + 3);
        checkRun("rst_mid/restart", c0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
